// File: rtl/ex_operand_forward_stage_if.sv
// Bundle between ID/EX control and the EX-stage operand muxes.
// The optional FWD_STATS_EN counters are plain ports on the stage, not part of this bundle.
interface ex_operand_forward_stage_if #(
    parameter int DW = 64,
    parameter int RW = 5
);
    logic            id_valid;
    logic [RW-1:0]   id_rn;
    logic [RW-1:0]   id_rm;
    logic [RW-1:0]   id_rd;
    logic            id_regwrite;
    logic            id_memread;
    logic            id_alusrc;
    logic [DW-1:0]   id_rd1;
    logic [DW-1:0]   id_rd2;
    logic [DW-1:0]   id_imm;
    logic            flush;
    logic [RW-1:0]   exmem_rd;
    logic            exmem_regwrite;
    logic [DW-1:0]   exmem_result;
    logic [RW-1:0]   memwb_rd;
    logic            memwb_regwrite;
    logic [DW-1:0]   memwb_result;

    logic            stall_o;
    logic            ex_valid;
    logic [RW-1:0]   ex_rd;
    logic            ex_regwrite;
    logic            ex_memread;
    logic [1:0]      sel_a;
    logic [1:0]      sel_b;
    logic [4*DW-1:0] mux_in_a;
    logic [4*DW-1:0] mux_in_b;

    modport master (
        output id_valid, id_rn, id_rm, id_rd, id_regwrite, id_memread, id_alusrc,
               id_rd1, id_rd2, id_imm, flush,
               exmem_rd, exmem_regwrite, exmem_result,
               memwb_rd, memwb_regwrite, memwb_result,
        input  stall_o, ex_valid, ex_rd, ex_regwrite, ex_memread,
               sel_a, sel_b, mux_in_a, mux_in_b
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rd, id_regwrite, id_memread, id_alusrc,
               id_rd1, id_rd2, id_imm, flush,
               exmem_rd, exmem_regwrite, exmem_result,
               memwb_rd, memwb_regwrite, memwb_result,
        output stall_o, ex_valid, ex_rd, ex_regwrite, ex_memread,
               sel_a, sel_b, mux_in_a, mux_in_b
    );
endinterface

// File: rtl/ex_operand_forward_stage.sv
// ID/EX register with operand forwarding selects and load-use stall/bubble insertion.
// Optional FWD_STATS_EN adds saturating forward/stall event counters.
module ex_operand_forward_stage #(
    parameter int DW = 64,
    parameter int RW = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    ex_operand_forward_stage_if.slave fwd_if
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]            o_stat_fwd_cnt,
    output logic [31:0]            o_stat_stall_cnt
`endif
);
    localparam logic [RW-1:0] XZR = RW'(31);

    logic            r_ex_valid;
    logic [RW-1:0]   r_ex_rn;
    logic [RW-1:0]   r_ex_rm;
    logic [RW-1:0]   r_ex_rd;
    logic            r_ex_regwrite;
    logic            r_ex_memread;
    logic            r_ex_alusrc;
    logic [DW-1:0]   r_ex_rd1;
    logic [DW-1:0]   r_ex_rd2;
    logic [DW-1:0]   r_ex_imm;

    logic            w_stall;
    logic [1:0]      w_sel_a;
    logic [1:0]      w_sel_b;

    // Both sources are compared even when B will take the immediate.
    assign w_stall = fwd_if.id_valid & r_ex_valid & r_ex_memread & (r_ex_rd != XZR) &
                     ((r_ex_rd == fwd_if.id_rn) | (r_ex_rd == fwd_if.id_rm));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_rn       <= '0;
            r_ex_rm       <= '0;
            r_ex_rd       <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_alusrc   <= 1'b0;
            r_ex_rd1      <= '0;
            r_ex_rd2      <= '0;
            r_ex_imm      <= '0;
        end else if (fwd_if.flush || w_stall) begin
            r_ex_valid    <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_alusrc   <= 1'b0;
        end else begin
            r_ex_valid    <= fwd_if.id_valid;
            r_ex_rn       <= fwd_if.id_rn;
            r_ex_rm       <= fwd_if.id_rm;
            r_ex_rd       <= fwd_if.id_rd;
            r_ex_regwrite <= fwd_if.id_valid & fwd_if.id_regwrite;
            r_ex_memread  <= fwd_if.id_valid & fwd_if.id_memread;
            r_ex_alusrc   <= fwd_if.id_valid & fwd_if.id_alusrc;
            r_ex_rd1      <= fwd_if.id_rd1;
            r_ex_rd2      <= fwd_if.id_rd2;
            r_ex_imm      <= fwd_if.id_imm;
        end
    end

    // The younger EX/MEM result wins over MEM/WB; the immediate overrides any B forwarding.
    always_comb begin
        w_sel_a = 2'd0;
        w_sel_b = 2'd0;
        if (r_ex_valid) begin
            if (fwd_if.exmem_regwrite && fwd_if.exmem_rd == r_ex_rn && r_ex_rn != XZR)
                w_sel_a = 2'd1;
            else if (fwd_if.memwb_regwrite && fwd_if.memwb_rd == r_ex_rn && r_ex_rn != XZR)
                w_sel_a = 2'd2;

            if (r_ex_alusrc)
                w_sel_b = 2'd3;
            else if (fwd_if.exmem_regwrite && fwd_if.exmem_rd == r_ex_rm && r_ex_rm != XZR)
                w_sel_b = 2'd1;
            else if (fwd_if.memwb_regwrite && fwd_if.memwb_rd == r_ex_rm && r_ex_rm != XZR)
                w_sel_b = 2'd2;
        end
    end

    assign fwd_if.stall_o     = w_stall;
    assign fwd_if.ex_valid    = r_ex_valid;
    assign fwd_if.ex_rd       = r_ex_rd;
    assign fwd_if.ex_regwrite = r_ex_regwrite;
    assign fwd_if.ex_memread  = r_ex_memread;
    assign fwd_if.sel_a       = w_sel_a;
    assign fwd_if.sel_b       = w_sel_b;
    assign fwd_if.mux_in_a    = {r_ex_imm, fwd_if.memwb_result, fwd_if.exmem_result, r_ex_rd1};
    assign fwd_if.mux_in_b    = {r_ex_imm, fwd_if.memwb_result, fwd_if.exmem_result, r_ex_rd2};

`ifdef FWD_STATS_EN
    logic w_fwd_event;

    assign w_fwd_event = r_ex_valid &
                         ((w_sel_a == 2'd1) | (w_sel_a == 2'd2) |
                          (w_sel_b == 2'd1) | (w_sel_b == 2'd2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_stat_fwd_cnt   <= '0;
            o_stat_stall_cnt <= '0;
        end else begin
            if (w_fwd_event && o_stat_fwd_cnt != 32'hFFFF_FFFF)
                o_stat_fwd_cnt <= o_stat_fwd_cnt + 32'd1;
            if (w_stall && o_stat_stall_cnt != 32'hFFFF_FFFF)
                o_stat_stall_cnt <= o_stat_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ex_operand_forward_stage.sv
// Directed table-driven bench for ex_operand_forward_stage plus reset/load-use/flush sequences.
// Define FWD_STATS_EN for both bench and RTL to also check the event counters.
module tb_ex_operand_forward_stage;
    localparam int DW = 64;
    localparam int RW = 5;

    logic clk;
    logic reset_n;
    int   cmpCount;
    int   failCount;

    ex_operand_forward_stage_if #(.DW(DW), .RW(RW)) bus ();

`ifdef FWD_STATS_EN
    logic [31:0] statFwd;
    logic [31:0] statStall;
    logic [31:0] snapFwd;
    logic [31:0] snapStall;
`endif

    ex_operand_forward_stage #(.DW(DW), .RW(RW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .fwd_if           (bus.slave)
`ifdef FWD_STATS_EN
        ,
        .o_stat_fwd_cnt   (statFwd),
        .o_stat_stall_cnt (statStall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [RW-1:0] rn;
        logic [RW-1:0] rm;
        logic [RW-1:0] rd;
        logic          regwrite;
        logic          alusrc;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [RW-1:0] exRd;
        logic          exWr;
        logic [DW-1:0] exRes;
        logic [RW-1:0] wbRd;
        logic          wbWr;
        logic [DW-1:0] wbRes;
        logic          expValid;
        logic          expRegwrite;
        logic [1:0]    expSelA;
        logic [1:0]    expSelB;
        logic [DW-1:0] expOpA;
        logic [DW-1:0] expOpB;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        cmpCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic valid, input logic [RW-1:0] rn, input logic [RW-1:0] rm,
                         input logic [RW-1:0] rd, input logic regwrite, input logic memread);
        bus.id_valid    = valid;
        bus.id_rn       = rn;
        bus.id_rm       = rm;
        bus.id_rd       = rd;
        bus.id_regwrite = regwrite;
        bus.id_memread  = memread;
        bus.id_alusrc   = 1'b0;
    endtask

    task automatic setFwd(input logic [RW-1:0] exRd, input logic exWr, input logic [DW-1:0] exRes,
                          input logic [RW-1:0] wbRd, input logic wbWr, input logic [DW-1:0] wbRes);
        bus.exmem_rd       = exRd;
        bus.exmem_regwrite = exWr;
        bus.exmem_result   = exRes;
        bus.memwb_rd       = wbRd;
        bus.memwb_regwrite = wbWr;
        bus.memwb_result   = wbRes;
    endtask

    task automatic applyStimulus(input vec_t v);
        setId(v.valid, v.rn, v.rm, v.rd, v.regwrite, 1'b0);
        bus.id_alusrc = v.alusrc;
        bus.id_rd1    = v.rd1;
        bus.id_rd2    = v.rd2;
        bus.id_imm    = v.imm;
        bus.flush     = 1'b0;
        setFwd(v.exRd, v.exWr, v.exRes, v.wbRd, v.wbWr, v.wbRes);
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        check($sformatf("v%0d ex_valid", idx), DW'(bus.ex_valid), DW'(v.expValid));
        check($sformatf("v%0d ex_regwrite", idx), DW'(bus.ex_regwrite), DW'(v.expRegwrite));
        check($sformatf("v%0d sel_a", idx), DW'(bus.sel_a), DW'(v.expSelA));
        check($sformatf("v%0d sel_b", idx), DW'(bus.sel_b), DW'(v.expSelB));
        check($sformatf("v%0d opA", idx), bus.mux_in_a[v.expSelA*DW +: DW], v.expOpA);
        check($sformatf("v%0d opB", idx), bus.mux_in_b[v.expSelB*DW +: DW], v.expOpB);
        check($sformatf("v%0d stall", idx), DW'(bus.stall_o), '0);
    endtask

    initial begin
        cmpCount  = 0;
        failCount = 0;

        vecs[0] = '{1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 64'h111, 64'h222, 64'h0,
                    5'd3, 1'b1, 64'hAAA, 5'd9, 1'b1, 64'hBBB,
                    1'b1, 1'b1, 2'd1, 2'd0, 64'hAAA, 64'h222};
        vecs[1] = '{1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 64'h111, 64'h222, 64'h0,
                    5'd5, 1'b1, 64'hAAA1, 5'd5, 1'b1, 64'hBBB1,
                    1'b1, 1'b1, 2'd1, 2'd1, 64'hAAA1, 64'hAAA1};
        vecs[2] = '{1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 64'h111, 64'h222, 64'h0,
                    5'd5, 1'b0, 64'hAAA1, 5'd5, 1'b1, 64'hBBB1,
                    1'b1, 1'b1, 2'd2, 2'd2, 64'hBBB1, 64'hBBB1};
        vecs[3] = '{1'b1, 5'd31, 5'd1, 5'd6, 1'b1, 1'b0, 64'h333, 64'h444, 64'h0,
                    5'd31, 1'b1, 64'hAAA, 5'd31, 1'b1, 64'hBBB,
                    1'b1, 1'b1, 2'd0, 2'd0, 64'h333, 64'h444};
        vecs[4] = '{1'b1, 5'd10, 5'd4, 5'd6, 1'b1, 1'b1, 64'h555, 64'h666, 64'hDDD,
                    5'd4, 1'b1, 64'hAAA, 5'd10, 1'b0, 64'hBBB,
                    1'b1, 1'b1, 2'd0, 2'd3, 64'h555, 64'hDDD};
        vecs[5] = '{1'b0, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 64'h777, 64'h888, 64'h0,
                    5'd3, 1'b1, 64'hAAA, 5'd4, 1'b1, 64'hBBB,
                    1'b0, 1'b0, 2'd0, 2'd0, 64'h777, 64'h888};
        vecs[6] = '{1'b1, 5'd12, 5'd13, 5'd14, 1'b0, 1'b0, 64'h999, 64'hAB, 64'h0,
                    5'd12, 1'b0, 64'hAAA, 5'd13, 1'b1, 64'hCCC,
                    1'b1, 1'b0, 2'd0, 2'd2, 64'h999, 64'hCCC};
        vecs[7] = '{1'b1, 5'd20, 5'd21, 5'd22, 1'b1, 1'b0, 64'h1, 64'h2, 64'h3,
                    5'd7, 1'b1, 64'hAAA, 5'd8, 1'b1, 64'hBBB,
                    1'b1, 1'b1, 2'd0, 2'd0, 64'h1, 64'h2};

        reset_n = 1'b0;
        setId(1'b0, '0, '0, '0, 1'b0, 1'b0);
        bus.id_rd1 = '0;
        bus.id_rd2 = '0;
        bus.id_imm = '0;
        bus.flush  = 1'b0;
        setFwd('0, 1'b0, '0, '0, 1'b0, '0);
        #1;
        check("reset ex_valid", DW'(bus.ex_valid), '0);
        check("reset stall", DW'(bus.stall_o), '0);
        check("reset mux_a slot0", bus.mux_in_a[DW-1:0], '0);
`ifdef FWD_STATS_EN
        check("reset fwd_cnt", DW'(statFwd), '0);
        check("reset stall_cnt", DW'(statStall), '0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            tick();
            checkOutput(i, vecs[i]);
        end

        // Asynchronous reset in the middle of a forwarding cycle.
        @(negedge clk);
        applyStimulus(vecs[0]);
        tick();
        check("pre-reset sel_a", DW'(bus.sel_a), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset ex_valid", DW'(bus.ex_valid), '0);
        check("async reset sel_a", DW'(bus.sel_a), '0);
        check("async reset sel_b", DW'(bus.sel_b), '0);
        check("async reset stall", DW'(bus.stall_o), '0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post-reset ex_valid", DW'(bus.ex_valid), 64'd1);
        check("post-reset sel_a", DW'(bus.sel_a), 64'd1);
        check("post-reset opA", bus.mux_in_a[127:64], 64'hAAA);

        // Load-use: LDUR X2 in EX, dependent ADD in ID.
        @(negedge clk);
        setId(1'b1, 5'd7, 5'd8, 5'd2, 1'b1, 1'b1);
        setFwd('0, 1'b0, '0, '0, 1'b0, '0);
        tick();
        check("ldur ex_memread", DW'(bus.ex_memread), 64'd1);
        setId(1'b1, 5'd2, 5'd9, 5'd3, 1'b1, 1'b0);
        bus.id_rd1 = 64'h5A5A;
        #1;
        check("load-use stall", DW'(bus.stall_o), 64'd1);
`ifdef FWD_STATS_EN
        snapStall = statStall;
`endif
        tick();
        check("bubble ex_valid", DW'(bus.ex_valid), '0);
        check("bubble ex_memread", DW'(bus.ex_memread), '0);
        check("bubble stall clears", DW'(bus.stall_o), '0);
`ifdef FWD_STATS_EN
        check("load-use stall_cnt", DW'(statStall), DW'(snapStall + 32'd1));
`endif
        setFwd('0, 1'b0, '0, 5'd2, 1'b1, 64'hEEE);
        tick();
        check("add ex_valid", DW'(bus.ex_valid), 64'd1);
        check("add ex_rd", DW'(bus.ex_rd), 64'd3);
        check("add sel_a memwb", DW'(bus.sel_a), 64'd2);
        check("add opA", bus.mux_in_a[191:128], 64'hEEE);

        // Flush and stall in the same cycle.
        @(negedge clk);
        setId(1'b1, 5'd7, 5'd8, 5'd2, 1'b1, 1'b1);
        setFwd('0, 1'b0, '0, '0, 1'b0, '0);
        tick();
        setId(1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        check("flush+stall stall", DW'(bus.stall_o), 64'd1);
`ifdef FWD_STATS_EN
        snapFwd   = statFwd;
        snapStall = statStall;
`endif
        tick();
        check("flush+stall ex_valid", DW'(bus.ex_valid), '0);
        check("flush+stall ex_regwrite", DW'(bus.ex_regwrite), '0);
`ifdef FWD_STATS_EN
        check("flush+stall stall_cnt", DW'(statStall), DW'(snapStall + 32'd1));
        check("flush+stall fwd_cnt", DW'(statFwd), DW'(snapFwd));
`endif
        bus.flush = 1'b0;

        // Flush alone kills a valid instruction.
        @(negedge clk);
        setId(1'b1, 5'd11, 5'd12, 5'd5, 1'b1, 1'b0);
        tick();
        check("pre-flush ex_valid", DW'(bus.ex_valid), 64'd1);
        setId(1'b1, 5'd13, 5'd14, 5'd6, 1'b1, 1'b0);
        bus.flush = 1'b1;
        tick();
        check("flush ex_valid", DW'(bus.ex_valid), '0);
        check("flush ex_regwrite", DW'(bus.ex_regwrite), '0);
        bus.flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end
endmodule
